// File: rtl/prng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prng_arbiter
// Description : Round-robin scheduler that time-shares one 64-bit LCG state
//               register and one external registered permutation stage
//               among NUM_REQ requesters. A granted transaction advances the
//               LCG, waits for the permutation stage, and returns the
//               permuted word tagged with the requester index. Seed loading
//               is accepted only while idle.
// Ports       : clk, rst         clock / synchronous active-high reset
//               req, gnt         level requests / registered one-hot grant
//               seed_load, seed  LCG state load (IDLE only)
//               busy             high whenever the FSM is not IDLE
//               perm_din         LCG state, drives the permutation stage
//               perm_dout        registered permutation output (1 cycle)
//               rand_valid       one-cycle result pulse
//               rand_data        permuted word, held between pulses
//               rand_id          owner index of rand_data
// Revision    : 1.0 - initial release
// ============================================================================
module prng_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [63:0] SEED    = 64'hCAFEF00DD15EA5E5,
    parameter logic [63:0] MULT    = 64'h5851F42D4C957F2D,
    parameter logic [63:0] INC     = 64'h14057B7F4C2BAE1B,
    parameter int          ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic               seed_load,
    input  logic [63:0]        seed,
    output logic               busy,
    output logic [63:0]        perm_din,
    input  logic [63:0]        perm_dout,
    output logic               rand_valid,
    output logic [63:0]        rand_data,
    output logic [ID_W-1:0]    rand_id
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_advance = 2'd1;
    localparam logic [1:0] c_st_perm    = 2'd2;
    localparam logic [1:0] c_st_capture = 2'd3;

    localparam logic [ID_W-1:0]    c_id_one  = ID_W'(1);
    localparam logic [ID_W-1:0]    c_id_last = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_gnt_one = NUM_REQ'(1);

    logic [1:0]         r_state;
    logic [63:0]        r_lcg_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_cur_id;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_rand_valid;
    logic [63:0]        r_rand_data;
    logic [ID_W-1:0]    r_rand_id;

    logic [NUM_REQ-1:0] w_req_hi;
    logic [ID_W-1:0]    w_hi_idx;
    logic [ID_W-1:0]    w_lo_idx;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_ptr_next;
    logic [63:0]        w_lcg_next;

    // Round-robin pick: requests at or above the pointer take priority; if
    // none exist, the search wraps to the lowest set request overall.
    always_comb begin
        w_req_hi = '0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_hi[i] = req[i] && (ID_W'(i) >= r_ptr);
        end
        // Scanning downward lets the lowest set bit be the last assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_hi_idx = ID_W'(i);
            end
            if (req[i]) begin
                w_lo_idx = ID_W'(i);
            end
        end
        w_idx      = (|w_req_hi) ? w_hi_idx : w_lo_idx;
        w_ptr_next = (w_idx == c_id_last) ? '0 : (w_idx + c_id_one);
    end

    // Product is taken in a 64-bit context so the upper bits fall away.
    assign w_lcg_next = r_lcg_state * MULT + INC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_lcg_state  <= SEED;
            r_ptr        <= '0;
            r_cur_id     <= '0;
            r_gnt        <= '0;
            r_rand_valid <= 1'b0;
            r_rand_data  <= '0;
            r_rand_id    <= '0;
        end else begin
            r_rand_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (seed_load) begin
                        r_lcg_state <= seed;
                    end else if (|req) begin
                        r_gnt    <= c_gnt_one << w_idx;
                        r_cur_id <= w_idx;
                        r_ptr    <= w_ptr_next;
                        r_state  <= c_st_advance;
                    end
                end
                c_st_advance: begin
                    r_lcg_state <= w_lcg_next;
                    r_state     <= c_st_perm;
                end
                c_st_perm: begin
                    // External stage registers perm_din during this cycle.
                    r_state <= c_st_capture;
                end
                c_st_capture: begin
                    r_rand_data  <= perm_dout;
                    r_rand_id    <= r_cur_id;
                    r_rand_valid <= 1'b1;
                    r_gnt        <= '0;
                    r_state      <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign busy       = (r_state != c_st_idle);
    assign perm_din   = r_lcg_state;
    assign rand_valid = r_rand_valid;
    assign rand_data  = r_rand_data;
    assign rand_id    = r_rand_id;

endmodule
`default_nettype wire

// File: tb/tb_prng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prng_arbiter
// Description : Self-checking bench for prng_arbiter. Supplies a registered
//               reference permutation stage, runs a table of directed
//               single-request transactions, then hand-written sequences
//               for round-robin fairness, ignored/deferring seed loads,
//               reset in PERM and a single-cycle request pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prng_arbiter;

    localparam logic [63:0] c_seed = 64'hCAFEF00DD15EA5E5;
    localparam logic [63:0] c_mult = 64'h5851F42D4C957F2D;
    localparam logic [63:0] c_inc  = 64'h14057B7F4C2BAE1B;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        seed_load;
    logic [63:0] seed;
    logic        busy;
    logic [63:0] perm_din;
    logic [63:0] perm_dout;
    logic        rand_valid;
    logic [63:0] rand_data;
    logic [1:0]  rand_id;

    int checks = 0;
    int errors = 0;

    prng_arbiter #(
        .NUM_REQ (4),
        .SEED    (c_seed),
        .MULT    (c_mult),
        .INC     (c_inc),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .seed_load  (seed_load),
        .seed       (seed),
        .busy       (busy),
        .perm_din   (perm_din),
        .perm_dout  (perm_dout),
        .rand_valid (rand_valid),
        .rand_data  (rand_data),
        .rand_id    (rand_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference permutation: half-swap then xor with a constant.
    function automatic logic [63:0] perm_f(input logic [63:0] x);
        return {x[31:0], x[63:32]} ^ 64'h9E3779B97F4A7C15;
    endfunction

    function automatic logic [63:0] lcg(input logic [63:0] x);
        logic [63:0] r;
        r = x * c_mult + c_inc;
        return r;
    endfunction

    initial perm_dout = '0;
    always @(posedge clk) perm_dout <= perm_f(perm_din);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_seed(input logic [63:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick;
        seed_load = 1'b0;
    endtask

    // One request cycle, then checks across T+1..T+5.
    task automatic run_txn(input logic [3:0] mask, input logic [3:0] egnt,
                           input logic [1:0] eid, input logic [63:0] edin);
        req = mask;
        tick;
        req = '0;
        chk("gnt_t1", gnt, egnt);
        chk("busy_t1", busy, 1);
        tick;
        chk("gnt_t2", gnt, egnt);
        chk("perm_din_t2", perm_din, edin);
        tick;
        chk("gnt_t3", gnt, egnt);
        chk("valid_t3", rand_valid, 0);
        tick;
        chk("valid_t4", rand_valid, 1);
        chk("id_t4", rand_id, eid);
        chk("data_t4", rand_data, perm_f(edin));
        chk("gnt_t4", gnt, 0);
        chk("busy_t4", busy, 0);
        tick;
        chk("valid_t5", rand_valid, 0);
        chk("data_hold", rand_data, perm_f(edin));
    endtask

    typedef struct {
        logic [63:0] seed;
        logic [3:0]  req;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_id;
        logic [63:0] exp_din;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int         rr_ids   [5];
        int         rr_cyc   [5];
        int         exp_rr   [5];
        int         n_valid;
        logic       seen;
        logic [1:0] seen_id;

        exp_rr = '{0, 1, 2, 3, 0};

        // ptr sequence after reset: 0 -> 1 -> 1 -> 2 -> 0 -> 0
        vecs[0] = '{64'h0,                4'b0001, 4'b0001, 2'd0, 64'h14057B7F4C2BAE1B};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 4'b0001, 4'b0001, 2'd0, 64'hBBB38751FF962EEE};
        vecs[2] = '{64'h1,                4'b0110, 4'b0010, 2'd1, 64'h6C576FAC98C12D48};
        vecs[3] = '{64'h0,                4'b1001, 4'b1000, 2'd3, 64'h14057B7F4C2BAE1B};
        vecs[4] = '{64'h0,                4'b1000, 4'b1000, 2'd3, 64'h14057B7F4C2BAE1B};

        rst       = 1'b1;
        req       = '0;
        seed_load = 1'b0;
        seed      = '0;
        tick;
        tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rand_valid, 0);
        chk("rst_data", rand_data, 0);
        chk("rst_id", rand_id, 0);
        chk("rst_perm_din", perm_din, c_seed);
        rst = 1'b0;
        tick;

        for (int v = 0; v < 5; v++) begin
            load_seed(vecs[v].seed);
            chk("seed_loaded", perm_din, vecs[v].seed);
            run_txn(vecs[v].req, vecs[v].exp_gnt, vecs[v].exp_id, vecs[v].exp_din);
        end

        // Round robin with all requests held for 20 cycles.
        n_valid = 0;
        req = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            tick;
            chk("rr_onehot", ((gnt & (gnt - 4'd1)) == 4'd0), 1);
            if (rand_valid) begin
                if (n_valid < 5) begin
                    rr_ids[n_valid] = int'(rand_id);
                    rr_cyc[n_valid] = k;
                end
                n_valid++;
            end
        end
        req = '0;
        chk("rr_count", n_valid, 5);
        for (int n = 0; n < 5 && n < n_valid; n++) begin
            chk("rr_id", rr_ids[n], exp_rr[n]);
            chk("rr_spacing", rr_cyc[n], 4 * (n + 1));
        end
        tick;
        chk("rr_idle", busy, 0);

        // seed_load during PERM is dropped.
        load_seed(64'h0);
        req = 4'b0001;
        tick;
        req = '0;
        tick;
        seed_load = 1'b1;
        seed      = 64'h1234;
        chk("perm_busy", busy, 1);
        tick;
        seed_load = 1'b0;
        chk("perm_ignore_din", perm_din, c_inc);
        tick;
        chk("perm_ignore_valid", rand_valid, 1);
        run_txn(4'b0001, 4'b0001, 2'd0, lcg(c_inc));

        // seed_load and req together: seed wins, grant one cycle later.
        seed_load = 1'b1;
        seed      = 64'h0;
        req       = 4'b0001;
        tick;
        seed_load = 1'b0;
        chk("both_gnt", gnt, 0);
        chk("both_busy", busy, 0);
        chk("both_din", perm_din, 0);
        run_txn(4'b0001, 4'b0001, 2'd0, c_inc);

        // Reset asserted while in PERM.
        req = 4'b0001;
        tick;
        req = '0;
        tick;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", rand_valid, 0);
        chk("abort_din", perm_din, c_seed);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("abort_no_valid", rand_valid, 0);
        end

        // Single-cycle pulse on req[2].
        req = 4'b0100;
        tick;
        req = '0;
        seen    = 1'b0;
        seen_id = '0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick;
            if (rand_valid) begin
                seen    = 1'b1;
                seen_id = rand_id;
            end
        end
        chk("pulse_seen", seen, 1);
        chk("pulse_id", seen_id, 2);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("pulse_gnt_idle", gnt, 0);
            chk("pulse_busy_idle", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
